// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 reads zero and is never busy; busy_count tracks the number of pending results.
module regfile_mp_sb #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_REGS     = 32,
    parameter int NUM_REGS_LOG = $clog2(NUM_REGS),
    parameter int NUM_READ     = 2,
    parameter int NUM_WRITE    = 2,
    parameter bit BYPASS       = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_READ*NUM_REGS_LOG-1:0] read_reg,
    output logic [NUM_READ*DATA_WIDTH-1:0]   read_data,
    output logic [NUM_READ-1:0]              read_busy,
    input  logic [NUM_WRITE-1:0]             write_en,
    input  logic [NUM_WRITE*NUM_REGS_LOG-1:0] write_reg,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  write_data,
    input  logic                             issue_en,
    input  logic [NUM_REGS_LOG-1:0]          issue_reg,
    output logic                             issue_ready,
    input  logic                             flush,
    output logic [NUM_REGS_LOG:0]            busy_count
);

    localparam int CW = NUM_REGS_LOG + 1;

    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q;
    logic [NUM_REGS-1:0]     busy_d;
    logic [CW-1:0]           count_d;
    logic [CW-1:0]           dec;
    logic [NUM_REGS-1:0]     hit;
    logic [DATA_WIDTH-1:0]   wval [NUM_REGS];
    logic [NUM_REGS_LOG-1:0] wr_addr [NUM_WRITE];
    logic [NUM_REGS_LOG-1:0] rd_addr [NUM_READ];
    logic                    issue_set;

    // Per-register write decode; ascending port order lets the highest index win.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        hit  = '0;
        wval = '{default: '0};
        for (int k = 0; k < NUM_WRITE; k++) begin
            wr_addr[k] = write_reg[k*NUM_REGS_LOG +: NUM_REGS_LOG];
            if (write_en[k] && wr_addr[k] != '0) begin
                hit[wr_addr[k]]  = 1'b1;
                wval[wr_addr[k]] = write_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign issue_ready = issue_en && !flush &&
                         (issue_reg == '0 || !busy_q[issue_reg] || hit[issue_reg]);
    assign issue_set   = issue_ready && issue_reg != '0;

    // A new producer's set overrides a same-cycle writeback clear on its register.
    always_comb begin
        busy_d = busy_q & ~hit;
        dec    = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (busy_q[r] && hit[r] && !(issue_set && issue_reg == NUM_REGS_LOG'(r)))
                dec = dec + CW'(1);
        end
        if (issue_set)
            busy_d[issue_reg] = 1'b1;
        count_d = busy_count - dec + ((issue_set && !busy_q[issue_reg]) ? CW'(1) : CW'(0));
        if (flush) begin
            busy_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            rd_addr[i] = read_reg[i*NUM_REGS_LOG +: NUM_REGS_LOG];
            if (rd_addr[i] == '0) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                read_busy[i]                          = 1'b0;
            end else if (BYPASS && hit[rd_addr[i]]) begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = wval[rd_addr[i]];
                read_busy[i]                          = 1'b0;
            end else begin
                read_data[i*DATA_WIDTH +: DATA_WIDTH] = regs[rd_addr[i]];
                read_busy[i]                          = busy_q[rd_addr[i]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register array is architecturally reset to zero, so it sits in the reset branch.
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
            busy_q     <= '0;
            busy_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (hit[r])
                    regs[r] <= wval[r];
            end
            busy_q     <= busy_d;
            busy_count <= count_d;
        end
    end

endmodule
